// File: rtl/sobel_edge_rows.sv
`default_nettype none
// ============================================================================
// sobel_edge_rows : row-parallel 3x3 Sobel edge magnitude with 2-row line buffer
// Revision 1.0 - initial release
// ============================================================================
module sobel_edge_rows #(
  parameter int SIZE   = 100,
  parameter int ROWS   = 100,
  parameter int THRESH = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE-1:0][7:0]     gray_arr_in,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic [SIZE-1:0][7:0]     edge_arr_out
);

  localparam int              CNT_W      = $clog2(ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [11:0]     THRESH_MAG = 12'(THRESH);

  typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIZE-1:0][7:0] prev1_q, prev1_d;
  logic [SIZE-1:0][7:0] prev2_q, prev2_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [CNT_W-1:0]     out_row_q, out_row_d;
  logic [SIZE-1:0][7:0] edge_q, edge_d;
  logic [SIZE-1:0][7:0] sobel_row;
  logic                 accept;

  // Weighted 1-2-1 sum of three pixels; max 1020 so 12 bits leave room for sign.
  function automatic logic [11:0] wsum(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] z);
    return {4'd0, x} + {3'd0, y, 1'b0} + {4'd0, z};
  endfunction

  for (genvar c = 0; c < SIZE; c++) begin : g_col
    if (c == 0 || c == SIZE - 1) begin : g_border
      assign sobel_row[c] = 8'd0;
    end else begin : g_inner
      logic [11:0] gx, gy, abs_x, abs_y, mag;
      assign gx = wsum(prev2_q[c+1], prev1_q[c+1], gray_arr_in[c+1])
                - wsum(prev2_q[c-1], prev1_q[c-1], gray_arr_in[c-1]);
      assign gy = wsum(gray_arr_in[c-1], gray_arr_in[c], gray_arr_in[c+1])
                - wsum(prev2_q[c-1], prev2_q[c], prev2_q[c+1]);
      assign abs_x = gx[11] ? (~gx + 12'd1) : gx;
      assign abs_y = gy[11] ? (~gy + 12'd1) : gy;
      assign mag   = abs_x + abs_y;
      if (THRESH > 0) begin : g_thresh
        assign sobel_row[c] = (mag >= THRESH_MAG) ? 8'hff : 8'h00;
      end else begin : g_sat
        assign sobel_row[c] = (mag > 12'd255) ? 8'hff : mag[7:0];
      end
    end
  end

  assign in_ready = (state_q != FLUSH);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev1_d     = prev1_q;
    prev2_d     = prev2_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_row_d   = out_row_q;
    edge_d      = edge_q;
    if (accept) begin
      prev2_d = prev1_q;
      prev1_d = gray_arr_in;
      cnt_d   = cnt_q + CNT_ONE;
    end
    case (state_q)
      FILL0: if (accept) state_d = FILL1;
      FILL1: begin
        if (accept) begin
          state_d     = RUN;
          out_valid_d = 1'b1;
          out_row_d   = '0;
          edge_d      = '0;
        end
      end
      RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_row_d   = cnt_q - CNT_ONE;
          edge_d      = sobel_row;
          if (cnt_q == LAST_ROW) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Bottom border row: the bubble that closes the frame.
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_row_d   = LAST_ROW;
        edge_d      = '0;
        cnt_d       = '0;
        state_d     = FILL0;
      end
      default: state_d = FILL0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL0;
      cnt_q       <= '0;
      prev1_q     <= '0;
      prev2_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      edge_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev1_q     <= prev1_d;
      prev2_q     <= prev2_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      edge_q      <= edge_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_row      = out_row_q;
  assign edge_arr_out = edge_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_rows.sv
`default_nettype none
// ============================================================================
// tb_sobel_edge_rows : scoreboard bench for sobel_edge_rows (THRESH 0 and 30)
// Revision 1.0 - initial release
// ============================================================================
module tb_sobel_edge_rows;

  localparam int SIZE = 100;
  localparam int ROWS = 100;
  localparam int THR1 = 30;

  typedef logic [SIZE-1:0][7:0] row_t;
  typedef struct {
    int   row;
    logic last;
    row_t e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  row_t       gray_in = '0;
  logic       rdy0, rdy1, v0, v1, l0, l1;
  logic [6:0] r0, r1;
  row_t       e0, e1;

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   n_checks = 0;
  int   n_pass = 0;
  row_t m_prev1 = '0;
  row_t m_prev2 = '0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  sobel_edge_rows #(.SIZE(SIZE), .ROWS(ROWS), .THRESH(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .gray_arr_in(gray_in), .out_valid(v0), .out_last(l0),
    .out_row(r0), .edge_arr_out(e0));

  sobel_edge_rows #(.SIZE(SIZE), .ROWS(ROWS), .THRESH(THR1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .gray_arr_in(gray_in), .out_valid(v1), .out_last(l1),
    .out_row(r1), .edge_arr_out(e1));

  task automatic check_eq(input string tag, input logic [SIZE*8-1:0] got,
                          input logic [SIZE*8-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic row_t ref_edge(input row_t a, input row_t b, input row_t d,
                                    input int thr);
    row_t e = '0;
    for (int c = 1; c < SIZE - 1; c++) begin
      int gx, gy, mag;
      gx = (int'(a[c+1]) + 2 * int'(b[c+1]) + int'(d[c+1]))
         - (int'(a[c-1]) + 2 * int'(b[c-1]) + int'(d[c-1]));
      gy = (int'(d[c-1]) + 2 * int'(d[c]) + int'(d[c+1]))
         - (int'(a[c-1]) + 2 * int'(a[c]) + int'(a[c+1]));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (thr > 0) e[c] = (mag >= thr) ? 8'd255 : 8'd0;
      else         e[c] = (mag > 255) ? 8'd255 : 8'(mag);
    end
    return e;
  endfunction

  function automatic row_t make_row(input int kind, input int r);
    row_t d;
    for (int c = 0; c < SIZE; c++) begin
      case (kind)
        0:       d[c] = 8'd128;
        1:       d[c] = (c < 50) ? 8'd0 : 8'd255;
        2:       d[c] = (r < 50) ? 8'd10 : 8'd20;
        default: d[c] = 8'($urandom);
      endcase
    end
    return d;
  endfunction

  task automatic model_accept(input row_t d);
    exp_t x0, x1;
    if (m_cnt >= 1) begin
      x0.row = m_cnt - 1; x0.last = 1'b0;
      x1.row = m_cnt - 1; x1.last = 1'b0;
      if (m_cnt == 1) begin
        x0.e = '0; x1.e = '0;
      end else begin
        x0.e = ref_edge(m_prev2, m_prev1, d, 0);
        x1.e = ref_edge(m_prev2, m_prev1, d, THR1);
      end
      sbq0.push_back(x0);
      sbq1.push_back(x1);
    end
    if (m_cnt == ROWS - 1) begin
      x0.row = ROWS - 1; x0.last = 1'b1; x0.e = '0;
      sbq0.push_back(x0);
      sbq1.push_back(x0);
    end
    m_prev2 = m_prev1;
    m_prev1 = d;
    m_cnt   = (m_cnt == ROWS - 1) ? 0 : m_cnt + 1;
  endtask

  // Present a row at a negedge, hold until in_ready, return 1ns after the accepting edge.
  task automatic send_row(input row_t d, input int idle);
    int waited = 0;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    gray_in  = d;
    while (!rdy0 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy0) check_eq("ready_timeout", 1'b0, 1'b1);
    model_accept(d);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_frame(input int kind, input int nrows, input bit gapped, input bit probe);
    for (int r = 0; r < nrows; r++) begin
      send_row(make_row(kind, r), gapped ? int'($urandom_range(0, 3)) : 0);
      if (probe && r == 2) begin
        check_eq("lat_valid", v0, 1'b1);
        check_eq("lat_row", r0, 7'd1);
      end
      if (probe && r == ROWS - 1) begin
        check_eq("flush_ready", rdy0, 1'b0);
        in_valid = 1'b1;
        gray_in  = make_row(3, 0);
        @(posedge clk);
        #1;
        check_eq("flush_last", l0, 1'b1);
        check_eq("flush_row", r0, 7'd99);
        check_eq("flush_ready_back", rdy0, 1'b1);
        in_valid = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst && v0) begin
      if (sbq0.size() == 0) check_eq("unexpected_out0", 1'b1, 1'b0);
      else begin
        x = sbq0.pop_front();
        check_eq("row0", r0, x.row);
        check_eq("last0", l0, x.last);
        check_eq("edge0", e0, x.e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (!rst && v1) begin
      if (sbq1.size() == 0) check_eq("unexpected_out1", 1'b1, 1'b0);
      else begin
        x = sbq1.pop_front();
        check_eq("row1", r1, x.row);
        check_eq("last1", l1, x.last);
        check_eq("edge1", e1, x.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_valid", v0, 1'b0);
    check_eq("rst_last", l0, 1'b0);
    check_eq("rst_row", r0, 7'd0);
    check_eq("rst_edge", e0, '0);
    check_eq("rst_ready", rdy0, 1'b1);
    #1 rst = 1'b0;

    run_frame(0, ROWS, 1'b0, 1'b1);
    run_frame(1, ROWS, 1'b0, 1'b0);
    run_frame(2, ROWS, 1'b0, 1'b0);

    // Partial frame (rows 0..40) aborted by reset.
    run_frame(3, 41, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", v0, 1'b0);
    check_eq("mid_rst_last", l0, 1'b0);
    check_eq("mid_rst_row", r0, 7'd0);
    check_eq("mid_rst_edge", e0, '0);
    check_eq("mid_rst_ready", rdy0, 1'b1);
    check_eq("mid_rst_sb_empty", sbq0.size(), 0);
    m_cnt   = 0;
    m_prev1 = '0;
    m_prev2 = '0;
    @(negedge clk);
    #2 rst = 1'b0;

    run_frame(3, ROWS, 1'b1, 1'b0);
    run_frame(3, ROWS, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    check_eq("sb0_drained", sbq0.size(), 0);
    check_eq("sb1_drained", sbq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
